scandoubler_vidin_writer: RTL

- Producer for the scandoubler SDRAM framebuffer write port (vidin_*); drives vidin_req, vidin_frame, vidin_x, vidin_y and vidin_d, and consumes vidin_ack.
- Captures core pixels (16-bit RGB565, one per pix_ce) into a two-slot ping-pong buffer of 16-word blocks.
- Raises a request per filled block and streams the words as the controller acks them.
- Sits between the core video output and the SDRAM controller; everything runs in the clk_96 domain.

---
 rtl/scandoubler_pkg.sv | 14 +
 rtl/scandoubler_linebuf.sv | 28 ++
 rtl/scandoubler_vidin_writer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/scandoubler_pkg.sv
// Shared constants and types for the scandoubler framebuffer writer.
package scandoubler_pkg;
  localparam int          BLOCK_WORDS = 16;
  localparam logic [15:0] PAD_WORD    = 16'h0000;
  localparam int          XW          = 11;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  typedef logic       slot_t;
  typedef logic [3:0] word_t;
endpackage

// File: rtl/scandoubler_linebuf.sv
// Two-slot block buffer: 32x16 simple dual-port RAM addressed {slot, word}.
// Registered read, one cycle latency; read data holds while rd_en_i is low.
module scandoubler_linebuf
  import scandoubler_pkg::*;
(
  input  logic        clk_i,
  input  logic        init_n_i,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [15:0] wr_dat_i,
  input  logic        rd_en_i,
  input  logic [4:0]  rd_addr_i,
  output logic [15:0] rd_dat_o
);
  logic [15:0] mem_q [2*BLOCK_WORDS];
  logic [15:0] rd_dat_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (!init_n_i)    rd_dat_q <= '0;
    else if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/scandoubler_vidin_writer.sv
// Packs core pixels into 16-word blocks and streams them to the SDRAM vidin port.
// Word n is presented the cycle after the n-th ack; pixels are dropped (overflow) when both slots are full.
module scandoubler_vidin_writer
  import scandoubler_pkg::*;
(
  input  logic          clk_96,
  input  logic          init_n,
  input  logic          pix_ce,
  input  logic [15:0]   pix_d,
  input  logic          pix_hs,
  input  logic          pix_vs,
  output logic          vidin_req,
  output logic [1:0]    vidin_frame,
  output logic [XW-1:0] vidin_x,
  output logic [XW-1:0] vidin_y,
  output logic [15:0]   vidin_d,
  input  logic          vidin_ack,
  output logic          overflow
);
  logic                   hs_q, vs_q, padding_q, padding_d, overflow_q;
  logic [1:0]             full_q, full_d, full_avail;
  slot_t                  fill_q, fill_d, drain_q, drain_d;
  word_t                  wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [XW-1:0]          x_q, x_d, y_q, y_d, vy_q;
  logic [1:0]             frame_q, frame_d, vf_q;
  logic [XW-5:0]          vx_hi_q;
  logic [1:0][XW-5:0]     base_xh_q;
  logic [1:0][XW-1:0]     base_y_q;
  logic [1:0][1:0]        base_f_q;
  rd_state_e              state_q, state_d;
  logic                   hs_rise, vs_rise, last_ack, wr_en, ovf_set, blk_done, rd_en, load;
  logic [15:0]            wr_dat;

  // Fill side: pixel capture, line-end padding and frame/line counters.
  always_comb begin
    hs_rise    = pix_hs & ~hs_q;
    vs_rise    = pix_vs & ~vs_q;
    last_ack   = (state_q == STREAM) && vidin_ack && (rcnt_q == word_t'(BLOCK_WORDS - 1));
    full_avail = full_q;
    if (last_ack) full_avail[drain_q] = 1'b0;
    wr_en   = 1'b0;
    wr_dat  = pix_d;
    ovf_set = 1'b0;
    if (padding_q) begin
      wr_en   = 1'b1;
      wr_dat  = PAD_WORD;
      ovf_set = pix_ce;
    end else if (pix_ce) begin
      if (!full_avail[fill_q]) wr_en = 1'b1;
      else                     ovf_set = 1'b1;
    end
    blk_done  = wr_en && (wcnt_q == word_t'(BLOCK_WORDS - 1));
    wcnt_d    = wr_en ? wcnt_q + 4'd1 : wcnt_q;
    x_d       = wr_en ? x_q + XW'(1) : x_q;
    y_d       = y_q;
    frame_d   = frame_q;
    padding_d = padding_q;
    if (padding_q && blk_done) begin
      padding_d = 1'b0;
      x_d       = '0;
      y_d       = y_q + XW'(1);
    end else if (hs_rise && !padding_q) begin
      if (wcnt_d != '0) padding_d = 1'b1;
      else begin
        x_d = '0;
        y_d = y_q + XW'(1);
      end
    end
    if (vs_rise) begin
      frame_d = frame_q + 2'd1;
      y_d     = '0;
    end
    full_d = full_avail;
    if (blk_done) full_d[fill_q] = 1'b1;
    fill_d = fill_q ^ blk_done;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[drain_q]) begin
          state_d = STREAM;
          rcnt_d  = '0;
          rd_en   = 1'b1;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (last_ack) begin
          state_d = IDLE;
          drain_d = ~drain_q;
          rcnt_d  = '0;
        end else if (vidin_ack) begin
          rcnt_d = rcnt_q + 4'd1;
          rd_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_96) begin
    if (!init_n) begin
      hs_q <= 1'b0; vs_q <= 1'b0; padding_q <= 1'b0; overflow_q <= 1'b0;
      full_q <= '0; fill_q <= 1'b0; drain_q <= 1'b0;
      wcnt_q <= '0; rcnt_q <= '0; x_q <= '0; y_q <= '0; frame_q <= '0;
      vy_q <= '0; vf_q <= '0; vx_hi_q <= '0;
      base_xh_q <= '0; base_y_q <= '0; base_f_q <= '0;
      state_q <= IDLE;
    end else begin
      hs_q <= pix_hs; vs_q <= pix_vs; padding_q <= padding_d;
      overflow_q <= overflow_q | ovf_set;
      full_q <= full_d; fill_q <= fill_d; drain_q <= drain_d;
      wcnt_q <= wcnt_d; rcnt_q <= rcnt_d; x_q <= x_d; y_q <= y_d; frame_q <= frame_d;
      state_q <= state_d;
      if (blk_done) begin
        base_xh_q[fill_q] <= x_q[XW-1:4];
        base_y_q[fill_q]  <= y_q;
        base_f_q[fill_q]  <= frame_q;
      end
      if (load) begin
        vx_hi_q <= base_xh_q[drain_q];
        vy_q    <= base_y_q[drain_q];
        vf_q    <= base_f_q[drain_q];
      end
    end
  end

  scandoubler_linebuf u_linebuf (
    .clk_i     (clk_96),
    .init_n_i  (init_n),
    .wr_en_i   (wr_en),
    .wr_addr_i ({fill_q, wcnt_q}),
    .wr_dat_i  (wr_dat),
    .rd_en_i   (rd_en),
    .rd_addr_i ({drain_q, rcnt_d}),
    .rd_dat_o  (vidin_d)
  );

  assign vidin_req   = (state_q == STREAM);
  assign vidin_x     = {vx_hi_q, rcnt_q};
  assign vidin_y     = vy_q;
  assign vidin_frame = vf_q;
  assign overflow    = overflow_q;
endmodule
